// File: rtl/data_bus_writeback_pkg.sv
// data_bus_writeback_pkg: shared CPU destination codes, reset values and store FSM states
package data_bus_writeback_pkg;
  typedef logic [2:0] dest_t;
  localparam dest_t DEST_A   = 3'd0;
  localparam dest_t DEST_MEM = 3'd1;
  localparam dest_t DEST_MDR = 3'd2;
  localparam dest_t DEST_SP  = 3'd3;
  localparam dest_t DEST_Y   = 3'd4;
  localparam dest_t DEST_X   = 3'd5;
  localparam logic [7:0] SP_RESET = 8'hFD;
  typedef enum logic {ST_IDLE, ST_REQ} store_state_t;
endpackage

// File: rtl/data_bus_writeback_if.sv
// data_bus_writeback_if: write-back strobe inputs and memory store handshake
interface data_bus_writeback_if;
  import data_bus_writeback_pkg::*;
  logic [7:0] in_data_bus;
  logic load_stb;
  dest_t load_dest;
  logic update_nz;
  logic [15:0] in_mem_addr;
  logic mem_wr_ack;
  logic mem_wr_req;
  logic [15:0] mem_wr_addr;
  logic [7:0] mem_wr_data;
  modport master (
    output in_data_bus, load_stb, load_dest, update_nz, in_mem_addr, mem_wr_ack,
    input mem_wr_req, mem_wr_addr, mem_wr_data
  );
  modport slave (
    input in_data_bus, load_stb, load_dest, update_nz, in_mem_addr, mem_wr_ack,
    output mem_wr_req, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/data_bus_writeback_store_handshake.sv
// store_handshake: memory store request FSM with ack timeout
module store_handshake
  import data_bus_writeback_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic store_stb,
  input  logic [7:0] wr_data_in,
  input  logic [15:0] wr_addr_in,
  input  logic mem_wr_ack,
  output logic mem_wr_req,
  output logic [15:0] mem_wr_addr,
  output logic [7:0] mem_wr_data,
  output logic busy,
  output logic store_reject,
  output logic mem_timeout
);
  localparam int CW = ACK_TIMEOUT > 1 ? $clog2(ACK_TIMEOUT) : 1;
  store_state_t state, next_state;
  logic [CW-1:0] cnt;
  logic expired;
  assign expired = cnt == CW'(ACK_TIMEOUT - 1);
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= next_state;
  // next state: ack wins over an expiring counter
  always_comb
    next_state = state == ST_IDLE ? (store_stb ? ST_REQ : ST_IDLE)
                                  : (mem_wr_ack || expired ? ST_IDLE : ST_REQ);
  // outputs decoded from state
  always_comb begin
    mem_wr_req = state == ST_REQ;
    busy = state == ST_REQ;
    store_reject = store_stb && state == ST_REQ;
  end
  // latch store payload, run the timeout counter, register the timeout pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      cnt <= '0;
      mem_timeout <= 1'b0;
    end else begin
      mem_timeout <= state == ST_REQ && !mem_wr_ack && expired;
      if (state == ST_IDLE && store_stb) begin
        mem_wr_addr <= wr_addr_in;
        mem_wr_data <= wr_data_in;
        cnt <= '0;
      end else if (state == ST_REQ && !expired) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/data_bus_writeback.sv
// data_bus_writeback: register bank, N/Z flags and memory store write-back
module data_bus_writeback
  import data_bus_writeback_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  data_bus_writeback_if.slave bus,
  output logic [7:0] out_a,
  output logic [7:0] out_x,
  output logic [7:0] out_y,
  output logic [7:0] out_mdr,
  output logic [7:0] out_sp,
  output logic flag_n,
  output logic flag_z,
  output logic busy,
  output logic load_err,
  output logic mem_timeout
);
  logic bad_dest, nz_dest, store_reject;
  assign bad_dest = bus.load_dest > DEST_X;
  assign nz_dest = bus.load_dest == DEST_A || bus.load_dest == DEST_X || bus.load_dest == DEST_Y;
  store_handshake #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_store (
    .clk(clk),
    .rst_n(rst_n),
    .store_stb(bus.load_stb && bus.load_dest == DEST_MEM),
    .wr_data_in(bus.in_data_bus),
    .wr_addr_in(bus.in_mem_addr),
    .mem_wr_ack(bus.mem_wr_ack),
    .mem_wr_req(bus.mem_wr_req),
    .mem_wr_addr(bus.mem_wr_addr),
    .mem_wr_data(bus.mem_wr_data),
    .busy(busy),
    .store_reject(store_reject),
    .mem_timeout(mem_timeout)
  );
  // register loads, flag updates and the rejected-strobe pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_a <= '0;
      out_x <= '0;
      out_y <= '0;
      out_mdr <= '0;
      out_sp <= SP_RESET;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      load_err <= 1'b0;
    end else begin
      load_err <= bus.load_stb && bad_dest || store_reject;
      if (bus.load_stb && bus.load_dest == DEST_A) out_a <= bus.in_data_bus;
      if (bus.load_stb && bus.load_dest == DEST_X) out_x <= bus.in_data_bus;
      if (bus.load_stb && bus.load_dest == DEST_Y) out_y <= bus.in_data_bus;
      if (bus.load_stb && bus.load_dest == DEST_MDR) out_mdr <= bus.in_data_bus;
      if (bus.load_stb && bus.load_dest == DEST_SP) out_sp <= bus.in_data_bus;
      if (bus.load_stb && bus.update_nz && nz_dest) begin
        flag_n <= bus.in_data_bus[7];
        flag_z <= bus.in_data_bus == 8'h00;
      end
    end
endmodule

// File: tb/tb_data_bus_writeback.sv
// tb_data_bus_writeback: directed vector table plus store handshake sequences
module tb_data_bus_writeback;
  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] out_a, out_x, out_y, out_mdr, out_sp;
  logic flag_n, flag_z, busy, load_err, mem_timeout;
  int tests = 0;
  int failed = 0;
  data_bus_writeback_if bus();
  data_bus_writeback #(.ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .out_a(out_a), .out_x(out_x), .out_y(out_y), .out_mdr(out_mdr), .out_sp(out_sp),
    .flag_n(flag_n), .flag_z(flag_z), .busy(busy), .load_err(load_err), .mem_timeout(mem_timeout)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0] dest;
    logic [7:0] data;
    logic nz;
    logic [41:0] exp_st;
    logic exp_err;
  } vec_t;
  vec_t v[9];
  logic [41:0] st;
  assign st = {out_a, out_x, out_y, out_mdr, out_sp, flag_n, flag_z};
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic strobe(input logic [2:0] dest, input logic [7:0] data, input logic nz, input logic [15:0] addr);
    bus.load_stb = 1'b1;
    bus.load_dest = dest;
    bus.in_data_bus = data;
    bus.update_nz = nz;
    bus.in_mem_addr = addr;
    tick;
    bus.load_stb = 1'b0;
  endtask
  initial begin
    int req_cnt, to_cnt;
    v[0] = '{3'd0, 8'h80, 1'b1, {8'h80, 8'h00, 8'h00, 8'h00, 8'hFD, 1'b1, 1'b0}, 1'b0};
    v[1] = '{3'd5, 8'h00, 1'b1, {8'h80, 8'h00, 8'h00, 8'h00, 8'hFD, 1'b0, 1'b1}, 1'b0};
    v[2] = '{3'd2, 8'h7F, 1'b1, {8'h80, 8'h00, 8'h00, 8'h7F, 8'hFD, 1'b0, 1'b1}, 1'b0};
    v[3] = '{3'd3, 8'h10, 1'b1, {8'h80, 8'h00, 8'h00, 8'h7F, 8'h10, 1'b0, 1'b1}, 1'b0};
    v[4] = '{3'd4, 8'hFF, 1'b0, {8'h80, 8'h00, 8'hFF, 8'h7F, 8'h10, 1'b0, 1'b1}, 1'b0};
    v[5] = '{3'd4, 8'h01, 1'b1, {8'h80, 8'h00, 8'h01, 8'h7F, 8'h10, 1'b0, 1'b0}, 1'b0};
    v[6] = '{3'd6, 8'hAA, 1'b1, {8'h80, 8'h00, 8'h01, 8'h7F, 8'h10, 1'b0, 1'b0}, 1'b1};
    v[7] = '{3'd7, 8'h00, 1'b1, {8'h80, 8'h00, 8'h01, 8'h7F, 8'h10, 1'b0, 1'b0}, 1'b1};
    v[8] = '{3'd5, 8'hC3, 1'b1, {8'h80, 8'hC3, 8'h01, 8'h7F, 8'h10, 1'b1, 1'b0}, 1'b0};
    rst_n = 1'b0;
    bus.load_stb = 1'b0;
    bus.load_dest = 3'd0;
    bus.in_data_bus = 8'h00;
    bus.update_nz = 1'b0;
    bus.in_mem_addr = 16'h0000;
    bus.mem_wr_ack = 1'b0;
    tick;
    tick;
    chk("reset_regs", 64'(st), 64'({8'h00, 8'h00, 8'h00, 8'h00, 8'hFD, 1'b0, 1'b0}));
    chk("reset_ctl", 64'({bus.mem_wr_req, busy, load_err, mem_timeout, bus.mem_wr_addr, bus.mem_wr_data}), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      strobe(v[i].dest, v[i].data, v[i].nz, 16'h0000);
      chk($sformatf("vec%0d_regs", i), 64'(st), 64'(v[i].exp_st));
      chk($sformatf("vec%0d_err", i), 64'(load_err), 64'(v[i].exp_err));
    end
    strobe(3'd1, 8'h5A, 1'b0, 16'h0200);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ack_req_c%0d", i), 64'({bus.mem_wr_req, busy, bus.mem_wr_addr, bus.mem_wr_data}), 64'({2'b11, 16'h0200, 8'h5A}));
      if (i == 2) bus.mem_wr_ack = 1'b1;
      tick;
    end
    bus.mem_wr_ack = 1'b0;
    chk("ack_done", 64'({bus.mem_wr_req, busy, mem_timeout}), 64'd0);
    bus.mem_wr_ack = 1'b1;
    tick;
    bus.mem_wr_ack = 1'b0;
    chk("idle_ack_ignored", 64'({bus.mem_wr_req, busy, load_err}), 64'd0);
    strobe(3'd1, 8'h3C, 1'b0, 16'h1234);
    req_cnt = 0;
    to_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.mem_wr_req) req_cnt++;
      if (mem_timeout) to_cnt++;
      tick;
    end
    chk("timeout_req_cycles", 64'(req_cnt), 64'd16);
    chk("timeout_pulses", 64'(to_cnt), 64'd1);
    chk("timeout_idle", 64'({bus.mem_wr_req, busy}), 64'd0);
    strobe(3'd1, 8'h3D, 1'b0, 16'h1235);
    repeat (15) tick;
    chk("last_cycle_req", 64'(bus.mem_wr_req), 64'd1);
    bus.mem_wr_ack = 1'b1;
    tick;
    bus.mem_wr_ack = 1'b0;
    chk("ack_beats_timeout", 64'({bus.mem_wr_req, mem_timeout}), 64'd0);
    tick;
    chk("ack_beats_timeout_late", 64'(mem_timeout), 64'd0);
    strobe(3'd1, 8'h11, 1'b0, 16'h0300);
    strobe(3'd1, 8'h99, 1'b0, 16'hFFFF);
    chk("busy_store_err", 64'({load_err, bus.mem_wr_addr, bus.mem_wr_data}), 64'({1'b1, 16'h0300, 8'h11}));
    strobe(3'd7, 8'h00, 1'b1, 16'h0000);
    chk("dest7_err", 64'({load_err, bus.mem_wr_data}), 64'({1'b1, 8'h11}));
    chk("dest7_regs", 64'(st), 64'(v[8].exp_st));
    strobe(3'd0, 8'h42, 1'b0, 16'h0000);
    chk("busy_reg_load", 64'({out_a, busy, load_err}), 64'({8'h42, 1'b1, 1'b0}));
    bus.mem_wr_ack = 1'b1;
    strobe(3'd1, 8'h77, 1'b0, 16'h0400);
    bus.mem_wr_ack = 1'b0;
    chk("ack_cycle_store_err", 64'({load_err, bus.mem_wr_req, bus.mem_wr_data}), 64'({2'b10, 8'h11}));
    strobe(3'd1, 8'hE1, 1'b0, 16'h0500);
    tick;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 64'({bus.mem_wr_req, busy, mem_timeout, out_sp, out_a}), 64'({3'b000, 8'hFD, 8'h00}));
    to_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (mem_timeout) to_cnt++;
    end
    chk("rst_no_timeout", 64'(to_cnt), 64'd0);
    rst_n = 1'b1;
    strobe(3'd0, 8'h05, 1'b0, 16'h0000);
    chk("first_load_after_rst", 64'(out_a), 64'h05);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/data_bus_writeback.md
DATA_BUS_WRITEBACK -- requirements
Module: data_bus_writeback

Interface
REQ-001 Parameter ACK_TIMEOUT, default 16: maximum cycles MEM_WR_REQ stays high without MEM_WR_ACK.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 IN_DATA_BUS  input  8  internal data bus value to be written back.
REQ-005 LOAD_STB  input  1  one-cycle write-back strobe.
REQ-006 LOAD_DEST  input  3  destination: 0=A, 1=memory store, 2=MDR, 3=SP, 4=Y, 5=X, 6/7 invalid.
REQ-007 UPDATE_NZ  input  1  update N/Z flags from IN_DATA_BUS on this load.
REQ-008 IN_MEM_ADDR  input  16  target address for a memory store.
REQ-009 MEM_WR_ACK  input  1  memory accepted the write.
REQ-010 OUT_A, OUT_X, OUT_Y, OUT_MDR, OUT_SP  output  8 each  register contents.
REQ-011 FLAG_N, FLAG_Z  output  1 each  negative/zero flags.
REQ-012 MEM_WR_REQ  output  1  memory write request.
REQ-013 MEM_WR_ADDR  output  16; MEM_WR_DATA  output  8  held store address/data.
REQ-014 BUSY  output  1  store in progress.
REQ-015 LOAD_ERR  output  1  one-cycle pulse: rejected strobe.
REQ-016 MEM_TIMEOUT  output  1  one-cycle pulse: store abandoned.

Function
REQ-017 Register loads (dest 0,2,3,4,5) SHALL capture IN_DATA_BUS on the edge where LOAD_STB=1; new value visible the following cycle (latency 1).
REQ-018 Register loads SHALL be accepted regardless of BUSY.
REQ-019 With UPDATE_NZ=1 on a load to A, X or Y: FLAG_N <= IN_DATA_BUS[7], FLAG_Z <= (IN_DATA_BUS==0), same edge; flags hold otherwise, including on MDR/SP/memory loads.
REQ-020 Store FSM states: IDLE, REQ. BUSY=1 exactly in REQ.
REQ-021 IDLE, LOAD_STB=1, LOAD_DEST=1 -> REQ; latch IN_DATA_BUS into MEM_WR_DATA and IN_MEM_ADDR into MEM_WR_ADDR; clear timeout counter.
REQ-022 In REQ: MEM_WR_REQ=1, MEM_WR_ADDR/DATA stable until exit.
REQ-023 REQ with MEM_WR_ACK=1 -> IDLE next edge; MEM_WR_REQ low the following cycle.
REQ-024 REQ, counter reaching ACK_TIMEOUT-1 without ACK -> IDLE, MEM_TIMEOUT pulsed one cycle; ACK in that same cycle takes priority (no timeout).
REQ-025 Store strobe while in REQ (including the ACK cycle) SHALL be ignored and pulse LOAD_ERR one cycle later.
REQ-026 LOAD_STB with LOAD_DEST 6 or 7 SHALL change no state and pulse LOAD_ERR.
REQ-027 MEM_WR_ACK in IDLE SHALL be ignored.
REQ-028 Timeout counter width SHALL be $clog2(ACK_TIMEOUT); no wrap beyond ACK_TIMEOUT-1.

Reset
REQ-029 RST_N low SHALL immediately force: A, X, Y, MDR = 8'h00; SP = 8'hFD; FLAG_N=0, FLAG_Z=0; FSM=IDLE; MEM_WR_REQ=0, MEM_WR_ADDR=0, MEM_WR_DATA=0; BUSY, LOAD_ERR, MEM_TIMEOUT = 0; counter = 0.
REQ-030 Reset asserted mid-store SHALL abandon it without pulsing MEM_TIMEOUT.
REQ-031 First load accepted on the first rising edge after RST_N deasserts.

Structure
REQ-032 Destination codes (DEST_A, DEST_MEM, DEST_MDR, DEST_SP, DEST_Y, DEST_X) and SP reset value SHALL live in the shared CPU package, using the same code per register as the data-bus source select.
REQ-033 One sub-module, store_handshake, SHALL contain the store FSM and timeout counter; register bank and flags stay in the top.

Verification
REQ-034 LOAD_STB, DEST=0, bus=8'h80, UPDATE_NZ=1 -> next cycle OUT_A=8'h80, FLAG_N=1, FLAG_Z=0.
REQ-035 DEST=5, bus=8'h00, UPDATE_NZ=1, then DEST=2, bus=8'h7F, UPDATE_NZ=1 -> OUT_X=0, FLAG_Z=1 after both; OUT_MDR=8'h7F.
REQ-036 Store DEST=1, bus=8'h5A, addr=16'h0200, ACK after 3 cycles -> MEM_WR_REQ high 3 cycles with 0200/5A held, BUSY mirrors, then low.
REQ-037 Store with no ACK, ACK_TIMEOUT=16 -> MEM_WR_REQ high 16 cycles, MEM_TIMEOUT one pulse, FSM IDLE.
REQ-038 Second store during REQ plus DEST=7 strobe -> two LOAD_ERR pulses, MEM_WR_DATA unchanged, no register change.
REQ-039 RST_N low mid-store, asynchronously between edges -> MEM_WR_REQ=0, OUT_SP=8'hFD immediately, no MEM_TIMEOUT.
